ring_osc_freq_meter: RTL and testbench

Parametrised multi-channel ring-oscillator block. Each channel is an enable-gated odd-length inverter ring. The ring output is synchronised into clk and its rising edges are counted over a programmable gate window. A start/busy/done FSM sequences each measurement, and the per-channel counts are latched for readout. Used for on-die delay/PVT characterisation and as the entropy-source health monitor.

---
 rtl/ring_osc_freq_meter.sv | 128 ++++++++++++
 tb/tb_ring_osc_freq_meter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: gated inverter rings, synchronised edge
// counters over a programmable gate window, sequenced by an IDLE/ARM/GATE/DONE FSM.
module ring_osc_freq_meter #(
    parameter int CHANNELS    = 2,
    parameter int STAGES      = 5,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int USE_EXT_OSC = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [GATE_W-1:0]         gate_len,
    input  logic [CHANNELS-1:0]       osc_ext,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       overflow,
    output logic [CHANNELS-1:0]       osc_out
);

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          arm_cnt;
    logic [GATE_W-1:0]   glen_q, gcnt;
    logic [CHANNELS-1:0] en_q, ring_en, osc_raw;
    logic [CHANNELS-1:0] osc_p0, osc_p1, osc_p2, edg_p2;
    logic [CNT_W-1:0]    work [CHANNELS];
    logic [CNT_W-1:0]    work_nxt [CHANNELS];
    logic [CHANNELS-1:0] ovf_work, ovf_nxt;

    // Saturating increment; MSB of the result flags an attempted wrap.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return {1'b1, v};
        return {1'b0, v + CNT_W'(1)};
    endfunction

    if ((STAGES < 3) || (STAGES % 2 == 0)) begin : g_bad_stages
        $error("ring_osc_freq_meter: STAGES must be odd and >= 3");
    end

    assign ring_en = en_q & {CHANNELS{(state == ARM) || (state == GATE)}};

    if (USE_EXT_OSC != 0) begin : g_ext
        assign osc_raw = osc_ext & ring_en;
    end else begin : g_ring
        logic unused_ext;
        assign unused_ext = ^osc_ext;
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            (* keep = "true", preserve = "true" *) logic [STAGES-1:0] stg;
            // Odd inversion count closes into an oscillator; NAND parks the ring when disabled.
            assign stg[0] = ~(ring_en[i] & stg[STAGES-1]);
            for (genvar j = 1; j < STAGES; j++) begin : g_stage
                assign stg[j] = ~stg[j-1];
            end
            assign osc_raw[i] = ~stg[0];
        end
    end

    assign osc_out = osc_raw;
    assign edg_p2  = osc_p1 & ~osc_p2;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ARM;
            ARM:  if (arm_cnt == 2'd2) state_nxt = (glen_q == '0) ? DONE : GATE;
            GATE: if (gcnt == glen_q - GATE_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ovf_nxt = ovf_work;
        for (int c = 0; c < CHANNELS; c++) begin
            work_nxt[c] = work[c];
            if (state == ARM) begin
                work_nxt[c] = '0;
                ovf_nxt[c]  = 1'b0;
            end else if ((state == GATE) && edg_p2[c] && en_q[c]) begin
                {ovf_nxt[c], work_nxt[c]} = sat_inc(work[c]) | {ovf_work[c], {CNT_W{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            arm_cnt  <= '0;
            gcnt     <= '0;
            glen_q   <= '0;
            en_q     <= '0;
            osc_p0   <= '0;
            osc_p1   <= '0;
            osc_p2   <= '0;
            ovf_work <= '0;
            count    <= '0;
            overflow <= '0;
            for (int c = 0; c < CHANNELS; c++) work[c] <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
            arm_cnt  <= (state == ARM) ? arm_cnt + 2'd1 : 2'd0;
            gcnt     <= (state == GATE) ? gcnt + GATE_W'(1) : '0;
            // p0/p1 synchronise the asynchronous ring, p2 holds the previous sample
            osc_p0   <= osc_raw;
            osc_p1   <= osc_p0;
            osc_p2   <= osc_p1;
            ovf_work <= ovf_nxt;
            for (int c = 0; c < CHANNELS; c++) work[c] <= work_nxt[c];
            if ((state == IDLE) && start) begin
                en_q   <= ch_en;
                glen_q <= gate_len;
            end
            if ((state_nxt == DONE) && (state != DONE)) begin
                overflow <= ovf_nxt;
                for (int c = 0; c < CHANNELS; c++) count[c*CNT_W +: CNT_W] <= work_nxt[c];
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed bench for ring_osc_freq_meter using external oscillator inputs derived from clk.
module tb_ring_osc_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  ch_en;
    logic [15:0] gate_len;
    logic [7:0]  ph = '0;
    logic [1:0]  osc_a, osc_b;
    logic        busy, done, busy8, done8;
    logic [31:0] count;
    logic [15:0] count8;
    logic [1:0]  overflow, overflow8, osc_out, osc_out8;

    int n_checks = 0;
    int n_fail   = 0;

    // values captured in the done cycle of the latest run
    int cap_c0, cap_c1, cap_c8;
    logic [1:0] cap_ovf, cap_ovf8;

    assign osc_a = {ph[2], ph[1]};   // ch0 period 4, ch1 period 8
    assign osc_b = {ph[2], ph[0]};   // ch0 period 2

    ring_osc_freq_meter #(.CHANNELS(2), .STAGES(5), .CNT_W(16), .GATE_W(16), .USE_EXT_OSC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .gate_len(gate_len),
        .osc_ext(osc_a), .busy(busy), .done(done), .count(count),
        .overflow(overflow), .osc_out(osc_out)
    );

    ring_osc_freq_meter #(.CHANNELS(2), .STAGES(5), .CNT_W(8), .GATE_W(16), .USE_EXT_OSC(1)) dut8 (
        .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .gate_len(gate_len),
        .osc_ext(osc_b), .busy(busy8), .done(done8), .count(count8),
        .overflow(overflow8), .osc_out(osc_out8)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        ph = ph + 8'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int got, input int exp, input int tol);
        check($sformatf("%s (value %0d, want %0d+/-%0d)", tag, got, exp, tol),
              64'((got >= exp - tol) && (got <= exp + tol)), 64'd1);
    endtask

    // Start one measurement; latency counted from the start edge k (n=1 is cycle k+1).
    task automatic run(input logic [1:0] en, input logic [15:0] g, input bit pulse_busy,
                       output int lat, output int ndone, output bit busy_ok);
        lat = -1; ndone = 0; busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; ch_en = en; gate_len = g;
        for (int n = 1; n <= int'(g) + 60; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    cap_c0 = int'(count[15:0]);  cap_c1 = int'(count[31:16]);
                    cap_c8 = int'(count8[7:0]);  cap_ovf = overflow; cap_ovf8 = overflow8;
                end
            end
            if ((lat < 0 || lat == n) && busy !== 1'b1) busy_ok = 1'b0;
            if (lat >= 0 && n == lat + 1 && busy !== 1'b0) busy_ok = 1'b0;
            start = (pulse_busy && (n == 2 || n == 3)) ? 1'b1 : 1'b0;
            if (lat >= 0 && n >= lat + 8) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int  lat, nd, nd_rst;
        bit  bok;
        rst = 1'b1; start = 1'b0; ch_en = '0; gate_len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_osc_out", osc_out, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single channel, period 4, 100-cycle gate
        run(2'b01, 16'd100, 1'b0, lat, nd, bok);
        check("t1_latency", 64'(lat), 104);
        check("t1_busy_window", bok, 1);
        check("t1_done_count", 64'(nd), 1);
        check_tol("t1_ch0", cap_c0, 25, 1);
        check("t1_ch1", 64'(cap_c1), 0);
        check("t1_overflow", cap_ovf, 0);

        // both channels, periods 4 and 8, 400-cycle gate
        run(2'b11, 16'd400, 1'b0, lat, nd, bok);
        check("t2_latency", 64'(lat), 404);
        check_tol("t2_ch0", cap_c0, 100, 1);
        check_tol("t2_ch1", cap_c1, 50, 1);

        // 8-bit counter saturation with a period-2 input
        run(2'b01, 16'd1000, 1'b0, lat, nd, bok);
        check("t3_ch0_sat", 64'(cap_c8), 255);
        check("t3_ovf8", cap_ovf8[0], 1);
        check_tol("t3_wide_ch0", cap_c0, 250, 1);
        check("t3_wide_ovf", cap_ovf, 0);

        // next short run clears the overflow flag
        run(2'b01, 16'd10, 1'b0, lat, nd, bok);
        check_tol("t4_ch0", cap_c8, 5, 1);
        check("t4_ovf8", cap_ovf8[0], 0);

        // zero-length gate, with start pulses during busy
        run(2'b11, 16'd0, 1'b1, lat, nd, bok);
        check("t5_latency", 64'(lat), 4);
        check("t5_busy_window", bok, 1);
        check("t5_done_count", 64'(nd), 1);
        check("t5_ch0", 64'(cap_c0), 0);
        check("t5_ch1", 64'(cap_c1), 0);

        // nonzero results to be wiped by a mid-gate reset
        run(2'b11, 16'd40, 1'b0, lat, nd, bok);
        check("t6_pre_count_nonzero", 64'(count != 0), 1);

        @(negedge clk);
        start = 1'b1; ch_en = 2'b11; gate_len = 16'd100;
        @(negedge clk);
        start = 1'b0;
        nd_rst = 0;
        for (int n = 2; n < 50; n++) begin
            @(negedge clk);
            if (done) nd_rst++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_count", count, 0);
        check("t6_overflow", overflow, 0);
        check("t6_osc_out", osc_out, 0);
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (done) nd_rst++;
        end
        check("t6_no_done", 64'(nd_rst), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
